thermometer_codec: RTL and testbench



---
 rtl/thermometer_codec_if.sv | 15 +
 rtl/thermometer_codec.sv | 61 ++++++
 tb/tb_thermometer_codec.sv | 127 ++++++++++++
 3 files changed

// File: rtl/thermometer_codec_if.sv
// Bundle for the thermometer codec: switch/mode inputs and LED/error results.
interface thermometer_codec_if #(
  parameter int K = 3,
  parameter int W = 2**K - 1
);
  logic [W-1:0] sw;
  logic         sel;
  logic [W-1:0] led;
  logic         err;

  // Driver side: supplies switches and mode, observes the result.
  modport master (output sw, sel, input led, err);
  // Codec side: consumes switches and mode, produces the result.
  modport slave  (input sw, sel, output led, err);
endinterface

// File: rtl/thermometer_codec.sv
// Selectable binary-to-thermometer encoder / thermometer-to-binary decoder.
// sel=0 encodes sw[K-1:0] into a thermometer word; sel=1 measures the low run
// of ones in sw and flags any set bit above that run. One registered stage.
module thermometer_codec #(
  parameter int K = 3
) (
  input logic              clk,
  input logic              rst,
  thermometer_codec_if.slave bus
);
  localparam int W = 2**K - 1;

  logic [W-1:0] enc_word;   // thermometer image of sw[K-1:0]
  logic [W-1:0] run_mask;   // bit i set when sw[i:0] are all ones
  logic [K-1:0] run_len;    // length of the low run of ones
  logic [W-1:0] led_d, led_q;
  logic         err_d, err_q;

  // Per-bit logic: bit i of the encoded word is set when n > i; the run mask
  // is a prefix-AND, so it is itself a thermometer word covering the low run.
  for (genvar gi = 0; gi < W; gi++) begin : g_bits
    localparam logic [K-1:0] IDX = K'(gi);
    assign enc_word[gi] = (bus.sw[K-1:0] > IDX);
    assign run_mask[gi] = &bus.sw[gi:0];
  end

  // Run length = number of ones in the prefix mask (bounded W-step loop).
  always_comb begin
    run_len = '0;
    for (int i = 0; i < W; i++) begin
      run_len = run_len + K'(run_mask[i]);
    end
  end

  // Next-state selection between encode and decode results.
  always_comb begin
    led_d = '0;
    err_d = 1'b0;
    if (bus.sel) begin
      led_d[K-1:0] = run_len;
      // Any one outside the low run means the word is not 0..01..1.
      err_d        = |(bus.sw & ~run_mask);
    end else begin
      led_d = enc_word;
    end
  end

  // Output register with synchronous reset taking priority over data.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q <= '0;
      err_q <= 1'b0;
    end else begin
      led_q <= led_d;
      err_q <= err_d;
    end
  end

  assign bus.led = led_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_thermometer_codec.sv
// Self-checking bench for thermometer_codec with a behavioural reference model.
module tb_thermometer_codec;
  localparam int K = 3;
  localparam int W = 2**K - 1;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   exp_led_q;
  int   exp_err_q;

  thermometer_codec_if #(.K(K)) bus ();

  thermometer_codec #(.K(K)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: encode gives (1<<n)-1; decode counts the low run of ones and
  // reports an error unless the word equals exactly that run.
  function automatic void model(input int sw_v, input int sel_v, input int rst_v,
                                output int led_e, output int err_e);
    int c;
    if (rst_v != 0) begin
      led_e = 0;
      err_e = 0;
    end else if (sel_v == 0) begin
      led_e = (1 << (sw_v % 8)) - 1;
      err_e = 0;
    end else begin
      c = 0;
      while (c < W && ((sw_v >> c) & 1) == 1) c++;
      led_e = c;
      err_e = (sw_v != ((1 << c) - 1)) ? 1 : 0;
    end
  endfunction

  // Apply one input set, confirm outputs hold until the edge, then check
  // the registered result one cycle later.
  task automatic step(input string tag, input int sw_v, input int sel_v, input int rst_v);
    int le, ee;
    bus.sw  = W'(sw_v);
    bus.sel = sel_v[0];
    rst     = rst_v[0];
    #1;
    check_val({tag, "_hold_led"}, int'(bus.led), exp_led_q);
    model(sw_v & ((1 << W) - 1), sel_v, rst_v, le, ee);
    @(posedge clk);
    #1;
    check_val({tag, "_led"}, int'(bus.led), le);
    check_val({tag, "_err"}, int'(bus.err), ee);
    $display("%s: rst=%0d sel=%0d sw=%07b -> led=%07b err=%0b", tag, rst_v, sel_v,
             sw_v[W-1:0], bus.led, bus.err);
    exp_led_q = le;
    exp_err_q = ee;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_led_q = 0;
    exp_err_q = 0;
    bus.sw    = '0;
    bus.sel   = 1'b0;
    rst       = 1'b1;
    // Bring outputs to a known state before hold checks begin.
    @(posedge clk);
    #1;

    // Reset with active decode inputs, then release.
    step("reset0", 7'h7F, 1, 1);
    step("reset1", 7'h7F, 1, 1);
    step("release", 7'h7F, 1, 0);
    check_val("release_led_const", int'(bus.led), 7);

    // Encode sweep across every n.
    for (int n = 0; n <= W; n++) step("enc_sweep", n, 0, 0);

    // Encode ignores upper switch bits.
    step("enc_upper_a", 7'b0001010, 0, 0);
    step("enc_upper_b", 7'b1111101, 0, 0);

    // Decode valid and invalid codes.
    step("dec_zero", 7'b0000000, 1, 0);
    step("dec_three", 7'b0000111, 1, 0);
    step("dec_full", 7'b1111111, 1, 0);
    step("dec_bad_a", 7'b0000101, 1, 0);
    step("dec_bad_b", 7'b0001010, 1, 0);
    step("dec_bad_c", 7'b1000000, 1, 0);

    // Mode switch with held switches.
    step("mode_enc", 7'b0000011, 0, 0);
    step("mode_dec", 7'b0000011, 1, 0);

    // Counting stimulus with a mode flip at cycle 10.
    for (int i = 0; i < 20; i++) step("count", i, (i >= 10) ? 1 : 0, 0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 200; i++) begin
      int sw_r, sel_r, rst_r;
      sel_r = int'($urandom_range(1, 0));
      rst_r = ($urandom_range(19, 0) == 0) ? 1 : 0;
      // Bias decode stimulus toward valid codes so both err values appear.
      if (sel_r == 1 && $urandom_range(1, 0) == 1)
        sw_r = (1 << $urandom_range(W, 0)) - 1;
      else
        sw_r = int'($urandom_range((1 << W) - 1, 0));
      step("rand", sw_r, sel_r, rst_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
